// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from the icache and
// holds one fetched instruction (with PC and PC+4) for the IF/ID latch.
module ifetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pcplusfour_out,
  output logic        valid_out,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {FETCH, HALTWAIT, HALTED} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] bpc_reg, bpc_next;
  logic [31:0] bp4_reg, bp4_next;
  logic [31:0] count_reg, count_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;
  logic        consume, capture, squash;

  assign consume = valid_reg & ~stall;
  // No request while a full buffer is stalled, so nothing is fetched speculatively.
  assign iREN    = (state_reg == FETCH) & (~valid_reg | ~stall) & ~RST;
  assign capture = iREN & ihit & ~redirect;
  assign squash  = redirect & (state_reg != HALTED);

  assign iaddr          = pc_reg;
  assign instr_out      = instr_reg;
  assign pc_out         = bpc_reg;
  assign pcplusfour_out = bp4_reg;
  assign valid_out      = valid_reg;
  assign halted         = halted_reg;
  assign fetch_count    = count_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    bpc_next    = bpc_reg;
    bp4_next    = bp4_reg;
    valid_next  = valid_reg;
    halted_next = halted_reg;
    count_next  = count_reg;

    // The downstream latch takes the buffered word on this edge regardless of redirect.
    if (consume)
      count_next = count_reg + 32'd1;

    if (squash) begin
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      state_next = FETCH;
    end else if (capture) begin
      instr_next = iload;
      bpc_next   = pc_reg;
      bp4_next   = pc_reg + 32'd4;
      valid_next = 1'b1;
      pc_next    = pc_reg + 32'd4;
      if (iload[31:26] == HALT_OP)
        state_next = HALTWAIT;
    end else if (consume) begin
      valid_next = 1'b0;
      if (state_reg == HALTWAIT) begin
        halted_next = 1'b1;
        state_next  = HALTED;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= FETCH;
      pc_reg     <= PC_INIT;
      instr_reg  <= 32'd0;
      bpc_reg    <= 32'd0;
      bp4_reg    <= 32'd0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      count_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      bpc_reg    <= bpc_next;
      bp4_reg    <= bp4_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage that sits between the instruction-cache port and the IF/ID pipeline latch; it is the producer side of the latch interface.
- Holds the PC and issues read requests to the icache (iREN/iaddr, ihit/iload).
- Buffers one fetched instruction together with its PC and PC+4 and presents it with a valid flag, honouring hazard-unit stall, branch/jump redirect and HALT.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
HALT_OP, 6'h3F, opcode (instr[31:26]) that stops fetching

Ports:
CLK  in  1  single system clock, all state on rising edge
RST  in  1  synchronous reset, active-high
iREN  out  1  icache read enable
iaddr  out  32  icache word address, equal to the current PC register
ihit  in  1  icache hit; iload is valid this cycle
iload  in  32  instruction word from icache
stall  in  1  hazard-unit stall; the same signal that freezes IF/ID
redirect  in  1  branch/jump taken, resolved downstream
redirect_pc  in  32  target PC when redirect=1
instr_out  out  32  buffered instruction to IF/ID instr_in
pc_out  out  32  PC of the buffered instruction
pcplusfour_out  out  32  pc_out+4
valid_out  out  1  buffer holds an instruction; IF/ID captures when valid_out & ~stall
halted  out  1  fetch permanently stopped after HALT consumed
fetch_count  out  32  number of instructions consumed downstream

Behaviour:
- Reset (RST=1 at a clock edge):
  - pc <= PC_INIT; state <= FETCH.
  - instr_out, pc_out, pcplusfour_out, valid_out, halted and fetch_count all <= 0.
  - iREN=0 combinationally while RST=1.
  - Reset overrides every other input, including a reset asserted while a miss is outstanding. Any in-flight ihit is discarded.
- States:
  - FETCH: normal operation.
  - HALTWAIT: a HALT is buffered; no new requests.
  - HALTED: terminal until RST.
- consume = valid_out & ~stall.
- iREN = (state==FETCH) & (~valid_out | ~stall) & ~RST.
- iaddr = pc at all times.
- capture = iREN & ihit & ~redirect. On capture:
  - instr_out <= iload; pc_out <= pc; pcplusfour_out <= pc+4; valid_out <= 1; pc <= pc+4.
  - If iload[31:26]==HALT_OP, state <= HALTWAIT.
- consume without capture: valid_out <= 0, and the data registers hold their values.
- consume and capture in the same cycle: the buffer is replaced. Back-to-back throughput is 1 instruction per cycle on hits.
- stall with valid_out=1: all buffer registers and pc hold, iREN=0 (no speculative fetch past a full buffer).
- Latency: ihit at edge N puts the instruction on the outputs with valid_out=1 after edge N. The PC is advanced after the same edge.
- Miss (iREN=1, ihit=0): pc and iaddr hold and iREN stays high until ihit. The icache tolerates an iaddr change during a miss.
- redirect=1, highest priority after RST, in FETCH or HALTWAIT:
  - pc <= redirect_pc; valid_out <= 0; state <= FETCH.
  - Any ihit in that cycle is discarded and pc is not incremented.
  - This applies even when stall=1: the buffered wrong-path instruction is squashed.
  - Any requirement that IF/ID flush its own contents is handled by the hazard unit, not by this block.
- redirect in HALTED is ignored.
- HALTWAIT: iREN=0. When consume occurs, valid_out <= 0, halted <= 1, state <= HALTED.
- HALTED: iREN=0, valid_out=0, halted=1, pc frozen.
- Arithmetic: pc+4 is computed modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0. redirect_pc[1:0] is passed through unchecked.
- fetch_count increments by 1 on every consume (including the consume of the HALT instruction) and wraps at 2^32.

Test Plan:
- Reset then steady hits: RST 1 cycle, ihit=1 every cycle, iload=0x2001_0005, 0x2002_0006, ... -> pc_out 0x0, 0x4, 0x8 on consecutive cycles; valid_out=1 continuously; fetch_count=3 after 3 consumes.
- Stall hold: valid_out=1 with pc_out=0x8; stall=1 for 3 cycles -> iREN=0 and outputs frozen at 0x8; stall drops -> iaddr=0xC fetched the next cycle; no instruction lost or duplicated.
- Miss: ihit=0 for 4 cycles at iaddr=0x10 -> iREN held at 1, iaddr=0x10 stable, valid_out=0 after the prior consume; ihit then yields pc_out=0x10.
- Redirect: redirect=1 with redirect_pc=0x40 in the same cycle as ihit at 0x14 -> 0x14 word discarded, valid_out=0; next capture has pc_out=0x40 and pcplusfour_out=0x44. Repeat with stall=1 -> buffer still squashed.
- HALT: iload=0xFC00_0000 captured at pc 0x20 -> iREN=0 next cycle; after consume, halted=1 and valid_out=0; a later redirect to 0x0 is ignored.
- Wrap and reset mid-miss: redirect_pc=0xFFFF_FFFC then hit -> pcplusfour_out=0x0 and next iaddr=0x0. Assert RST during an outstanding miss -> pc=PC_INIT and all outputs 0 the next cycle.
